pipeline_control_unit: RTL and testbench

- Parametrised, stateful ID-stage control unit for the pipelined CPU. Decodes the ID opcode and writes the EX-stage control word into an internal ID/EX register.
- Generates PC/IF enables, branch redirect and IF flush. Also detects load-use hazards, freezes the pipe on multi-cycle memory, and runs a resumable HALT state machine.
- Sits between the IF/ID register and the datapath; replaces the purely combinational decoder.

---
 rtl/pipeline_control_unit.sv | 230 +++++++++++++++++++++++
 tb/tb_pipeline_control_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_control_unit.sv
// ID-stage control unit: decodes the ID opcode into a registered EX control word and
// steers PC/IF enables, branch redirect, IF flush, load-use stalls, memory freeze and HALT.
module pipeline_control_unit #(
  parameter int unsigned ALU_OPW      = 3,
  parameter int unsigned RAW          = 4,
  parameter int unsigned FLUSH_CYCLES = 1,
  localparam int unsigned OPW         = 3 + ALU_OPW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OPW-1:0]     opcode,
  input  logic [RAW-1:0]     id_rs_a,
  input  logic [RAW-1:0]     id_rs_b,
  input  logic               id_use_a,
  input  logic               id_use_b,
  input  logic [RAW-1:0]     id_rd,
  input  logic               z,
  input  logic               s,
  input  logic               mem_ready,
  input  logic               resume,
  output logic               we3,
  output logic               we_flags,
  output logic               s_mem_in,
  output logic               s_addr,
  output logic               read,
  output logic               write,
  output logic [1:0]         s_wd3,
  output logic [ALU_OPW-1:0] op_alu,
  output logic               s_pc,
  output logic               flush_if,
  output logic               enable_pc,
  output logic               enable_if,
  output logic               stall,
  output logic               halted
);

  localparam int unsigned CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {RUN, FLUSH, HALTED} state_t;

  typedef struct packed {
    logic               we3;
    logic               we_flags;
    logic               s_mem_in;
    logic               s_addr;
    logic               read;
    logic               write;
    logic [1:0]         s_wd3;
    logic [ALU_OPW-1:0] op_alu;
    logic [RAW-1:0]     rd;
  } ex_t;

  state_t        state, state_nx;
  ex_t           ex, ex_nx, dec;
  logic [CW-1:0] cnt, cnt_nx;
  logic          halted_nx;
  logic          is_halt, jump_taken;
  logic          mem_wait, load_use;

  logic [2:0]         cls;
  logic [ALU_OPW-1:0] sub;
  logic [2:0]         sub3;

  assign cls  = opcode[OPW-1:OPW-3];
  assign sub  = opcode[OPW-4:0];
  assign sub3 = opcode[OPW-4:OPW-6];

  assign mem_wait = (ex.read | ex.write) & ~mem_ready;
  assign load_use = ex.read & ((id_use_a && (id_rs_a == ex.rd)) ||
                               (id_use_b && (id_rs_b == ex.rd)));

  // Opcode decode into an EX control word plus halt / jump-taken flags
  always_comb begin
    dec        = '0;
    dec.rd     = id_rd;
    is_halt    = 1'b0;
    jump_taken = 1'b0;
    case (cls)
      3'b000: is_halt = (sub == ALU_OPW'(1));
      3'b111: begin
        dec.we3      = 1'b1;
        dec.we_flags = 1'b1;
        dec.op_alu   = sub;
      end
      3'b110: begin
        case (sub3)
          3'b000:  jump_taken = 1'b1;
          3'b001:  jump_taken = ~s & ~z;
          3'b010:  jump_taken = ~z;
          3'b011:  jump_taken = z;
          default: jump_taken = 1'b0;
        endcase
      end
      3'b101: begin
        casez (sub3)
          3'b00?: begin
            dec.s_wd3 = 2'b01;
            dec.we3   = 1'b1;
          end
          3'b010: begin
            dec.s_addr = 1'b1;
            dec.write  = 1'b1;
          end
          3'b011: begin
            dec.s_wd3  = 2'b10;
            dec.s_addr = 1'b1;
            dec.read   = 1'b1;
            dec.we3    = 1'b1;
          end
          default: begin
            dec.s_wd3 = 2'b10;
            dec.read  = 1'b1;
            dec.we3   = 1'b1;
          end
        endcase
      end
      3'b100: begin
        dec.write    = 1'b1;
        dec.s_mem_in = sub3[2];
      end
      default: dec = dec;
    endcase
  end

  // State, EX register, flush counter and halted flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= RUN;
      ex     <= '0;
      cnt    <= '0;
      halted <= 1'b0;
    end else begin
      state  <= state_nx;
      ex     <= ex_nx;
      cnt    <= cnt_nx;
      halted <= halted_nx;
    end
  end

  // Next state; a memory wait freezes everything, including the flush counter
  always_comb begin
    state_nx  = state;
    ex_nx     = ex;
    cnt_nx    = cnt;
    halted_nx = halted;
    case (state)
      RUN: begin
        if (mem_wait) begin
          ex_nx = ex;
        end else if (load_use) begin
          ex_nx = '0;
        end else if (is_halt) begin
          ex_nx     = '0;
          halted_nx = 1'b1;
          state_nx  = HALTED;
        end else if (jump_taken) begin
          ex_nx = '0;
          if (FLUSH_CYCLES > 1) begin
            state_nx = FLUSH;
            cnt_nx   = CW'(FLUSH_CYCLES - 1);
          end
        end else begin
          ex_nx = dec;
        end
      end
      FLUSH: begin
        if (!mem_wait) begin
          ex_nx  = '0;
          cnt_nx = cnt - CW'(1);
          if (cnt == CW'(1)) state_nx = RUN;
        end
      end
      HALTED: begin
        ex_nx = '0;
        if (resume) begin
          halted_nx = 1'b0;
          state_nx  = RUN;
        end
      end
      default: state_nx = RUN;
    endcase
  end

  // Pipeline control; the resume cycle advances IF/ID so the HALT is not re-decoded
  always_comb begin
    s_pc      = 1'b0;
    flush_if  = 1'b0;
    enable_pc = 1'b0;
    enable_if = 1'b0;
    stall     = 1'b0;
    if (!reset) begin
      case (state)
        RUN: begin
          if (mem_wait || load_use) begin
            stall = 1'b1;
          end else if (!is_halt) begin
            enable_pc = 1'b1;
            enable_if = 1'b1;
            s_pc      = jump_taken;
            flush_if  = jump_taken;
          end
        end
        FLUSH: begin
          if (mem_wait) begin
            stall = 1'b1;
          end else begin
            flush_if  = 1'b1;
            enable_pc = 1'b1;
            enable_if = 1'b1;
          end
        end
        HALTED: begin
          enable_pc = resume;
          enable_if = resume;
        end
        default: stall = 1'b0;
      endcase
    end
  end

  assign we3      = ex.we3;
  assign we_flags = ex.we_flags;
  assign s_mem_in = ex.s_mem_in;
  assign s_addr   = ex.s_addr;
  assign read     = ex.read;
  assign write    = ex.write;
  assign s_wd3    = ex.s_wd3;
  assign op_alu   = ex.op_alu;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Scoreboard bench for pipeline_control_unit: one ALU_OPW=3/FLUSH_CYCLES=3 instance
// under directed vectors, plus an ALU_OPW=5 instance checked on its wide ALU decode.
module tb_pipeline_control_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = '0;
  logic [7:0] opcode2 = '0;
  logic [3:0] id_rs_a = '0, id_rs_b = '0, id_rd = '0;
  logic       id_use_a = 1'b0, id_use_b = 1'b0;
  logic       z = 1'b0, s = 1'b0, mem_ready = 1'b1, resume = 1'b0;

  logic       we3, we_flags, s_mem_in, s_addr, read, write;
  logic [1:0] s_wd3;
  logic [2:0] op_alu;
  logic       s_pc, flush_if, enable_pc, enable_if, stall, halted;

  logic       we3_2, we_flags_2, s_mem_in_2, s_addr_2, read_2, write_2;
  logic [1:0] s_wd3_2;
  logic [4:0] op_alu_2;
  logic       s_pc_2, flush_if_2, enable_pc_2, enable_if_2, stall_2, halted_2;

  always #5 clk = ~clk;

  pipeline_control_unit #(.ALU_OPW(3), .RAW(4), .FLUSH_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .id_rs_a(id_rs_a), .id_rs_b(id_rs_b), .id_use_a(id_use_a), .id_use_b(id_use_b),
    .id_rd(id_rd), .z(z), .s(s), .mem_ready(mem_ready), .resume(resume),
    .we3(we3), .we_flags(we_flags), .s_mem_in(s_mem_in), .s_addr(s_addr),
    .read(read), .write(write), .s_wd3(s_wd3), .op_alu(op_alu),
    .s_pc(s_pc), .flush_if(flush_if), .enable_pc(enable_pc), .enable_if(enable_if),
    .stall(stall), .halted(halted)
  );

  pipeline_control_unit #(.ALU_OPW(5), .RAW(4), .FLUSH_CYCLES(1)) dut_w (
    .clk(clk), .reset(reset), .opcode(opcode2),
    .id_rs_a(id_rs_a), .id_rs_b(id_rs_b), .id_use_a(id_use_a), .id_use_b(id_use_b),
    .id_rd(id_rd), .z(z), .s(s), .mem_ready(mem_ready), .resume(resume),
    .we3(we3_2), .we_flags(we_flags_2), .s_mem_in(s_mem_in_2), .s_addr(s_addr_2),
    .read(read_2), .write(write_2), .s_wd3(s_wd3_2), .op_alu(op_alu_2),
    .s_pc(s_pc_2), .flush_if(flush_if_2), .enable_pc(enable_pc_2), .enable_if(enable_if_2),
    .stall(stall_2), .halted(halted_2)
  );

  typedef struct packed {
    logic [4:0]  op2;
    logic        wf2;
    logic        halted;
    logic [10:0] ctl;
    logic [4:0]  pipe;
  } exp_t;

  // ctl = {we3, we_flags, s_mem_in, s_addr, read, write, s_wd3[1:0], op_alu[2:0]}
  localparam logic [10:0] C_0    = 11'b0_0_0_0_0_0_00_000;
  localparam logic [10:0] C_ALU2 = 11'b1_1_0_0_0_0_00_010;
  localparam logic [10:0] C_LI   = 11'b1_0_0_0_0_0_01_000;
  localparam logic [10:0] C_SWRR = 11'b0_0_0_1_0_1_00_000;
  localparam logic [10:0] C_LWRR = 11'b1_0_0_1_1_0_10_000;
  localparam logic [10:0] C_LWA  = 11'b1_0_0_0_1_0_10_000;
  localparam logic [10:0] C_SWA  = 11'b0_0_0_0_0_1_00_000;
  localparam logic [10:0] C_STI  = 11'b0_0_1_0_0_1_00_000;
  // pipe = {s_pc, flush_if, enable_pc, enable_if, stall}
  localparam logic [4:0] P_OFF = 5'b00000;
  localparam logic [4:0] P_RUN = 5'b00110;
  localparam logic [4:0] P_STL = 5'b00001;
  localparam logic [4:0] P_JMP = 5'b11110;
  localparam logic [4:0] P_FL  = 5'b01110;

  localparam logic [5:0] NOP = 6'b000_000, HALT = 6'b000_001, ALU2 = 6'b111_010;
  localparam logic [5:0] J = 6'b110_000, JPOS = 6'b110_001, JNZ = 6'b110_010, JZ = 6'b110_011;
  localparam logic [5:0] LI = 6'b101_000, SWRR = 6'b101_010, LWRR = 6'b101_011, LWA = 6'b101_100;
  localparam logic [5:0] SWA = 6'b100_000, STI = 6'b100_100;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Inputs staged by the stimulus and applied together just after the next rising edge
  logic       nx_reset = 1'b0, nx_mr = 1'b1, nx_z = 1'b0, nx_s = 1'b0, nx_resume = 1'b0;
  logic       nx_ua = 1'b0, nx_ub = 1'b0;
  logic [3:0] nx_ra = '0, nx_rb = '0, nx_rd = '0;
  logic [7:0] nx_op2 = '0;
  logic [5:0] x2 = '0;

  task automatic v(input logic [5:0] op, input logic h, input logic [10:0] c, input logic [4:0] p);
    exp_t e;
    @(posedge clk);
    #1;
    opcode = op; reset = nx_reset; mem_ready = nx_mr; z = nx_z; s = nx_s; resume = nx_resume;
    id_use_a = nx_ua; id_use_b = nx_ub; id_rs_a = nx_ra; id_rs_b = nx_rb; id_rd = nx_rd;
    opcode2 = nx_op2;
    e.op2 = x2[5:1]; e.wf2 = x2[0]; e.halted = h; e.ctl = c; e.pipe = p;
    sb.push_back(e);
  endtask

  // Monitor: every cycle presents a full output vector, compared mid-cycle
  always @(negedge clk) begin
    exp_t e, a;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      a.op2 = op_alu_2; a.wf2 = we_flags_2; a.halted = halted;
      a.ctl = {we3, we_flags, s_mem_in, s_addr, read, write, s_wd3, op_alu};
      a.pipe = {s_pc, flush_if, enable_pc, enable_if, stall};
      n_vec++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL vec%0d: got op2=%b wf2=%b halted=%b ctl=%b pipe=%b, expected op2=%b wf2=%b halted=%b ctl=%b pipe=%b",
                 n_vec - 1, a.op2, a.wf2, a.halted, a.ctl, a.pipe, e.op2, e.wf2, e.halted, e.ctl, e.pipe);
      end
    end
  end

  initial begin
    nx_reset = 1'b1;
    v(NOP, 0, C_0, P_OFF);                              // reset state
    nx_reset = 1'b0; nx_op2 = 8'b111_10110;
    v(ALU2, 0, C_0, P_RUN);
    nx_op2 = '0; x2 = {5'b10110, 1'b1};
    v(NOP, 0, C_ALU2, P_RUN);                           // ALU word lands in EX
    x2 = '0; nx_rd = 4'd5;
    v(LWRR, 0, C_0, P_RUN);
    nx_ua = 1'b1; nx_ra = 4'd5; nx_rd = 4'd1;
    v(ALU2, 0, C_LWRR, P_STL);                          // load-use stall
    v(ALU2, 0, C_0, P_RUN);                             // bubble, ALU issues
    nx_ua = 1'b0; nx_ra = '0;
    v(NOP, 0, C_ALU2, P_RUN);
    nx_rd = 4'd3;
    v(LWA, 0, C_0, P_RUN);
    nx_mr = 1'b0;
    v(NOP, 0, C_LWA, P_STL);                            // memory wait x3
    v(NOP, 0, C_LWA, P_STL);
    v(NOP, 0, C_LWA, P_STL);
    nx_mr = 1'b1;
    v(NOP, 0, C_LWA, P_RUN);
    nx_z = 1'b1;
    v(JZ, 0, C_0, P_JMP);                               // taken JZ, 3-cycle flush
    nx_z = 1'b0;
    v(ALU2, 0, C_0, P_FL);
    v(ALU2, 0, C_0, P_FL);
    v(JZ, 0, C_0, P_RUN);                               // JZ not taken
    v(JNZ, 0, C_0, P_JMP);
    v(NOP, 0, C_0, P_FL);
    nx_reset = 1'b1;
    v(NOP, 0, C_0, P_OFF);                              // reset mid-FLUSH
    nx_reset = 1'b0;
    v(NOP, 0, C_0, P_RUN);
    v(JPOS, 0, C_0, P_JMP);
    v(NOP, 0, C_0, P_FL);
    v(NOP, 0, C_0, P_FL);
    nx_s = 1'b1;
    v(JPOS, 0, C_0, P_RUN);                             // JPOS not taken with s=1
    nx_s = 1'b0;
    v(J, 0, C_0, P_JMP);
    v(NOP, 0, C_0, P_FL);
    v(NOP, 0, C_0, P_FL);
    v(LI, 0, C_0, P_RUN);
    v(SWRR, 0, C_LI, P_RUN);
    v(STI, 0, C_SWRR, P_RUN);
    v(SWA, 0, C_STI, P_RUN);
    v(NOP, 0, C_SWA, P_RUN);
    v(6'b110_100, 0, C_0, P_RUN);                       // undefined jump sub3 -> NOP
    v(6'b010_011, 0, C_0, P_RUN);                       // undefined class -> NOP
    v(NOP, 0, C_0, P_RUN);
    v(SWRR, 0, C_0, P_RUN);
    nx_mr = 1'b0;
    v(NOP, 0, C_SWRR, P_STL);
    nx_reset = 1'b1;
    v(NOP, 0, C_SWRR, P_OFF);                           // reset mid memory wait
    nx_reset = 1'b0;
    v(NOP, 0, C_0, P_RUN);
    nx_mr = 1'b1;
    v(HALT, 0, C_0, P_OFF);
    v(HALT, 1, C_0, P_OFF);
    v(HALT, 1, C_0, P_OFF);
    nx_resume = 1'b1;
    v(HALT, 1, C_0, P_RUN);                             // resume pulse
    nx_resume = 1'b0;
    v(ALU2, 0, C_0, P_RUN);
    nx_resume = 1'b1;
    v(NOP, 0, C_ALU2, P_RUN);                           // resume ignored in RUN
    nx_resume = 1'b0;
    v(NOP, 0, C_0, P_RUN);
    nx_rd = 4'd7;
    v(LWRR, 0, C_0, P_RUN);
    nx_ub = 1'b1; nx_rb = 4'd7; nx_ra = 4'd7; nx_rd = 4'd2;
    v(ALU2, 0, C_LWRR, P_STL);                          // load-use through rs_b
    v(ALU2, 0, C_0, P_RUN);
    nx_ub = 1'b0;
    v(NOP, 0, C_ALU2, P_RUN);
    nx_rd = 4'd7;
    v(LWRR, 0, C_0, P_RUN);
    nx_ub = 1'b1; nx_rb = 4'd2; nx_rd = 4'd2;
    v(ALU2, 0, C_LWRR, P_RUN);                          // unused rs_a match, no stall
    nx_ub = 1'b0;
    v(NOP, 0, C_ALU2, P_RUN);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d vectors left unchecked, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
